// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, register-address type and the load-use match helper.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        RUN,
        MEM_WAIT
    } ctrl_state_t;

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    function automatic logic load_use_hit(
        input logic      ex_memread,
        input reg_addr_t ex_rd,
        input reg_addr_t id_rs1,
        input reg_addr_t id_rs2,
        input logic      id_uses_rs2
    );
        return ex_memread && (ex_rd != REG_ZERO) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// Clear takes priority over increment; the count holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, branch flush, load-use stall.
// Control outputs are combinational; the FSM only tracks multi-cycle memory accesses.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs1,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs2,
    input  logic                  i_ifid_uses_rs2,
    input  logic                  i_idex_memread,
    input  logic [REG_ADDR_W-1:0] i_idex_rd,
    input  logic                  i_branch_taken,
    input  logic                  i_exmem_memread,
    input  logic                  i_exmem_memwrite,
    input  logic                  i_cnt_clr,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_ifid_flush,
    output logic                  o_idex_write,
    output logic                  o_idex_bubble,
    output logic                  o_exmem_write,
    output logic                  o_memwb_bubble,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count,
    output logic [CNT_W-1:0]      o_memwait_count
);

    localparam int unsigned WCNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned WCNT_INIT = (MEM_LAT >= 2) ? (MEM_LAT - 2) : 0;
    localparam logic        LAT_MULTI = (MEM_LAT > 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_next;

    logic w_mem_access;
    logic w_load_use;
    logic w_freeze;
    logic w_flush;
    logic w_stall;

    always_comb begin
        w_mem_access = i_exmem_memread | i_exmem_memwrite;
        w_load_use   = load_use_hit(i_idex_memread, i_idex_rd, i_ifid_rs1, i_ifid_rs2,
                                    i_ifid_uses_rs2);
        w_freeze     = ((r_state == MEM_WAIT) && (r_wcnt != '0)) ||
                       ((r_state == RUN) && w_mem_access && LAT_MULTI);
        // Freeze masks both branch and load-use; branch masks load-use.
        w_flush      = !w_freeze && i_branch_taken;
        w_stall      = !w_freeze && !i_branch_taken && w_load_use;
    end

    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        unique case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_state_next = MEM_WAIT;
                    w_wcnt_next  = WCNT_W'(WCNT_INIT);
                end
            end
            MEM_WAIT: begin
                if (r_wcnt != '0) begin
                    w_wcnt_next = r_wcnt - WCNT_W'(1);
                end else begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
                w_wcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RUN;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
        end
    end

    always_comb begin
        o_pc_write     = 1'b1;
        o_ifid_write   = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_write   = 1'b1;
        o_idex_bubble  = 1'b0;
        o_exmem_write  = 1'b1;
        o_memwb_bubble = 1'b0;
        o_busy         = 1'b0;
        if (i_rst) begin
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_idex_write   = 1'b0;
            o_exmem_write  = 1'b0;
            o_idex_bubble  = 1'b1;
            o_memwb_bubble = 1'b1;
        end else if (w_freeze) begin
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_idex_write   = 1'b0;
            o_exmem_write  = 1'b0;
            o_memwb_bubble = 1'b1;
            o_busy         = 1'b1;
        end else if (w_flush) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (w_stall) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_cnt_clr),
        .i_inc  (w_stall),
        .o_count(o_stall_count)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_cnt_clr),
        .i_inc  (w_flush),
        .o_count(o_flush_count)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_memwait_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (i_cnt_clr),
        .i_inc  (w_freeze),
        .o_count(o_memwait_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut_a (MEM_LAT=4, CNT_W=4) and dut_b (MEM_LAT=1, CNT_W=32)
// share all inputs; control outputs are packed {pc,ifid_w,flush,idex_w,bubble,exmem_w,mwb,busy}.
module tb_hazard_ctrl;

    localparam logic [7:0] C_DEF = 8'b1101_0100;
    localparam logic [7:0] C_RST = 8'b0000_1010;
    localparam logic [7:0] C_LU  = 8'b0001_1100;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_FRZ = 8'b0000_0011;

    logic       clk;
    logic       rst;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       ifid_uses_rs2;
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic       branch_taken;
    logic       exmem_memread;
    logic       exmem_memwrite;
    logic       cnt_clr;

    logic a_pc_w, a_ifid_w, a_flush, a_idex_w, a_bubble, a_exmem_w, a_mwb, a_busy;
    logic b_pc_w, b_ifid_w, b_flush, b_idex_w, b_bubble, b_exmem_w, b_mwb, b_busy;
    logic [3:0]  a_stall, a_flushc, a_memwait;
    logic [31:0] b_stall, b_flushc, b_memwait;
    logic [7:0]  ctl_a;
    logic [7:0]  ctl_b;

    int errors = 0;
    int checks = 0;

    assign ctl_a = {a_pc_w, a_ifid_w, a_flush, a_idex_w, a_bubble, a_exmem_w, a_mwb, a_busy};
    assign ctl_b = {b_pc_w, b_ifid_w, b_flush, b_idex_w, b_bubble, b_exmem_w, b_mwb, b_busy};

    hazard_ctrl #(.MEM_LAT(4), .CNT_W(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_ifid_rs1(ifid_rs1), .i_ifid_rs2(ifid_rs2),
        .i_ifid_uses_rs2(ifid_uses_rs2), .i_idex_memread(idex_memread), .i_idex_rd(idex_rd),
        .i_branch_taken(branch_taken), .i_exmem_memread(exmem_memread),
        .i_exmem_memwrite(exmem_memwrite), .i_cnt_clr(cnt_clr),
        .o_pc_write(a_pc_w), .o_ifid_write(a_ifid_w), .o_ifid_flush(a_flush),
        .o_idex_write(a_idex_w), .o_idex_bubble(a_bubble), .o_exmem_write(a_exmem_w),
        .o_memwb_bubble(a_mwb), .o_busy(a_busy), .o_stall_count(a_stall),
        .o_flush_count(a_flushc), .o_memwait_count(a_memwait)
    );

    hazard_ctrl #(.MEM_LAT(1), .CNT_W(32)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_ifid_rs1(ifid_rs1), .i_ifid_rs2(ifid_rs2),
        .i_ifid_uses_rs2(ifid_uses_rs2), .i_idex_memread(idex_memread), .i_idex_rd(idex_rd),
        .i_branch_taken(branch_taken), .i_exmem_memread(exmem_memread),
        .i_exmem_memwrite(exmem_memwrite), .i_cnt_clr(cnt_clr),
        .o_pc_write(b_pc_w), .o_ifid_write(b_ifid_w), .o_ifid_flush(b_flush),
        .o_idex_write(b_idex_w), .o_idex_bubble(b_bubble), .o_exmem_write(b_exmem_w),
        .o_memwb_bubble(b_mwb), .o_busy(b_busy), .o_stall_count(b_stall),
        .o_flush_count(b_flushc), .o_memwait_count(b_memwait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ifid_rs1       = 5'd0;
        ifid_rs2       = 5'd0;
        ifid_uses_rs2  = 1'b0;
        idex_memread   = 1'b0;
        idex_rd        = 5'd0;
        branch_taken   = 1'b0;
        exmem_memread  = 1'b0;
        exmem_memwrite = 1'b0;
        cnt_clr        = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        idex_memread  = 1'b1;
        idex_rd       = 5'd5;
        ifid_rs1      = 5'd5;
        branch_taken  = 1'b1;
        exmem_memread = 1'b1;
        step();
        step();
        checks++;
        if (ctl_a !== C_RST) begin
            errors++;
            $display("FAIL reset_ctl_a: got %b expected %b", ctl_a, C_RST);
        end
        checks++;
        if (ctl_b !== C_RST) begin
            errors++;
            $display("FAIL reset_ctl_b: got %b expected %b", ctl_b, C_RST);
        end
        checks++;
        if ({a_stall, a_flushc, a_memwait} !== 12'h000) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h expected 0 0 0",
                     a_stall, a_flushc, a_memwait);
        end
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            errors++;
            $display("FAIL idle_ctl_a: got %b expected %b", ctl_a, C_DEF);
        end
    endtask

    task automatic test_load_use();
        idex_memread = 1'b1;
        idex_rd      = 5'd5;
        ifid_rs1     = 5'd5;
        #1;
        checks++;
        if (ctl_a !== C_LU) begin
            errors++;
            $display("FAIL load_use_rs1: got %b expected %b", ctl_a, C_LU);
        end
        step();
        checks++;
        if (a_stall !== 4'd1) begin
            errors++;
            $display("FAIL stall_count_1: got %0d expected 1", a_stall);
        end
        ifid_rs1      = 5'd3;
        ifid_rs2      = 5'd5;
        ifid_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_LU) begin
            errors++;
            $display("FAIL load_use_rs2: got %b expected %b", ctl_a, C_LU);
        end
        step();
        ifid_uses_rs2 = 1'b0;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            errors++;
            $display("FAIL rs2_unused: got %b expected %b", ctl_a, C_DEF);
        end
        step();
        checks++;
        if (a_stall !== 4'd2) begin
            errors++;
            $display("FAIL stall_count_2: got %0d expected 2", a_stall);
        end
        set_idle();
    endtask

    task automatic test_load_use_x0();
        idex_memread = 1'b1;
        idex_rd      = 5'd0;
        ifid_rs1     = 5'd0;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            errors++;
            $display("FAIL load_x0_ctl: got %b expected %b", ctl_a, C_DEF);
        end
        step();
        checks++;
        if (a_stall !== 4'd2) begin
            errors++;
            $display("FAIL load_x0_count: got %0d expected 2", a_stall);
        end
        set_idle();
    endtask

    task automatic test_branch_priority();
        idex_memread = 1'b1;
        idex_rd      = 5'd5;
        ifid_rs1     = 5'd5;
        branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_BR) begin
            errors++;
            $display("FAIL branch_ctl: got %b expected %b", ctl_a, C_BR);
        end
        step();
        checks++;
        if ({a_flushc, a_stall} !== {4'd1, 4'd2}) begin
            errors++;
            $display("FAIL branch_counts: got flush=%0d stall=%0d expected flush=1 stall=2",
                     a_flushc, a_stall);
        end
        set_idle();
    endtask

    task automatic test_mem_wait();
        exmem_memread = 1'b1;
        branch_taken  = 1'b1;
        idex_memread  = 1'b1;
        idex_rd       = 5'd5;
        ifid_rs1      = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl_a !== C_FRZ) begin
                errors++;
                $display("FAIL freeze_cycle%0d: got %b expected %b", i + 1, ctl_a, C_FRZ);
            end
            checks++;
            if (ctl_b !== C_BR) begin
                errors++;
                $display("FAIL lat1_cycle%0d: got %b expected %b", i + 1, ctl_b, C_BR);
            end
            step();
        end
        branch_taken = 1'b0;
        idex_memread = 1'b0;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            errors++;
            $display("FAIL freeze_release: got %b expected %b", ctl_a, C_DEF);
        end
        step();
        checks++;
        if ({a_memwait, a_flushc, a_stall} !== {4'd3, 4'd1, 4'd2}) begin
            errors++;
            $display("FAIL freeze_counts: got memwait=%0d flush=%0d stall=%0d expected 3 1 2",
                     a_memwait, a_flushc, a_stall);
        end
    endtask

    task automatic test_back_to_back_reset();
        exmem_memread  = 1'b0;
        exmem_memwrite = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_FRZ) begin
            errors++;
            $display("FAIL back_to_back: got %b expected %b", ctl_a, C_FRZ);
        end
        step();
        checks++;
        if (a_memwait !== 4'd4) begin
            errors++;
            $display("FAIL b2b_memwait: got %0d expected 4", a_memwait);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_RST) begin
            errors++;
            $display("FAIL reset_mid_wait_ctl: got %b expected %b", ctl_a, C_RST);
        end
        step();
        rst = 1'b0;
        set_idle();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            errors++;
            $display("FAIL after_reset_run: got %b expected %b", ctl_a, C_DEF);
        end
        checks++;
        if ({a_stall, a_flushc, a_memwait} !== 12'h000) begin
            errors++;
            $display("FAIL after_reset_counts: got %h %h %h expected 0 0 0",
                     a_stall, a_flushc, a_memwait);
        end
    endtask

    task automatic test_saturation();
        idex_memread = 1'b1;
        idex_rd      = 5'd7;
        ifid_rs1     = 5'd7;
        repeat (20) step();
        checks++;
        if (a_stall !== 4'd15) begin
            errors++;
            $display("FAIL sat_stall_a: got %0d expected 15", a_stall);
        end
        checks++;
        if (b_stall !== 32'd20) begin
            errors++;
            $display("FAIL wide_stall_b: got %0d expected 20", b_stall);
        end
        cnt_clr = 1'b1;
        step();
        checks++;
        if ({a_stall, b_stall} !== 36'd0) begin
            errors++;
            $display("FAIL clr_priority: got a=%0d b=%0d expected 0 0", a_stall, b_stall);
        end
        set_idle();
        step();
        checks++;
        if (a_stall !== 4'd0) begin
            errors++;
            $display("FAIL clr_hold: got %0d expected 0", a_stall);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_branch_priority();
        test_mem_wait();
        test_back_to_back_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
